hhmm_clock_spi_command_controller: RTL

SPI-slave command front end for the HHMM 24-hour clock. It decodes framed byte commands from an external host, range-checks them, and drives the clock's time-load, reset-to-midnight and 12/24-hour mode controls. It sits between the board SPI pins and the clock/display datapath, and replaces the fixed initial values currently tied onto that datapath.

---
 rtl/hhmm_clock_pkg.sv | 38 +++
 rtl/spi_sync_edge.sv | 44 ++++
 rtl/hhmm_clock_spi_command_controller.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/hhmm_clock_pkg.sv
// Shared opcodes, FSM states, status bit positions and BCD limits for the HHMM clock SPI command front end.
package hhmm_clock_pkg;

  localparam logic [7:0] OP_SET_TIME    = 8'h01;
  localparam logic [7:0] OP_SET_MODE    = 8'h02;
  localparam logic [7:0] OP_CLEAR_TIME  = 8'h03;
  localparam logic [7:0] OP_READ_STATUS = 8'h04;

  localparam logic [7:0] HH_MAX = 8'h23;
  localparam logic [7:0] MS_MAX = 8'h59;

  localparam int STAT_MODE   = 0;
  localparam int STAT_RANGE  = 1;
  localparam int STAT_OPCODE = 2;
  localparam int STAT_ABORT  = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_OPCODE,
    ST_PAYLOAD,
    ST_EXECUTE,
    ST_DRAIN
  } state_e;

  function automatic logic bcd_ok(input logic [7:0] v, input logic [7:0] max);
    return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9) && (v <= max);
  endfunction

  function automatic logic time_ok(input logic [23:0] t);
    return bcd_ok(t[23:16], HH_MAX) && bcd_ok(t[15:8], MS_MAX) && bcd_ok(t[7:0], MS_MAX);
  endfunction

  // Index of the final frame bit for opcodes that carry a payload byte stream.
  function automatic logic [4:0] last_bit(input logic [7:0] op);
    return (op == OP_SET_TIME) ? 5'd31 : 5'd15;
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchronizer for an asynchronous SPI pin, with optional one-cycle rise/fall pulses.
module spi_sync_edge #(
  parameter logic RST_VAL = 1'b0,
  parameter bit   EDGE_EN = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic dout,
  output logic rise,
  output logic fall
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= din;
      sync_q <= meta_q;
    end
  end

  assign dout = sync_q;

  generate
    if (EDGE_EN) begin : g_edge
      logic prev_q;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) prev_q <= RST_VAL;
        else        prev_q <= sync_q;
      end
      assign rise = sync_q & ~prev_q;
      assign fall = ~sync_q & prev_q;
    end else begin : g_no_edge
      assign rise = 1'b0;
      assign fall = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/hhmm_clock_spi_command_controller.sv
// SPI-slave command decoder for the HHMM clock: loads BCD time, clears to midnight, sets 12/24h mode.
// Frames are byte commands; results appear two cycles after the last synchronized sclk rise.
module hhmm_clock_spi_command_controller
  import hhmm_clock_pkg::*;
#(
  parameter int SCLK_MIN_DIV = 8
) (
  input  logic        clock_1MHz,
  input  logic        reset_n,
  input  logic        spi_sclk,
  input  logic        spi_cs_n,
  input  logic        spi_mosi,
  output logic        spi_miso,
  output logic [23:0] set_time,
  output logic        set_load,
  output logic        mode_12h,
  output logic        cmd_err
);

  // Each sclk phase must outlast the synchronizer so rises and falls never coincide.
  if (SCLK_MIN_DIV < 4) begin : g_div_too_small
    $error("SCLK_MIN_DIV too small for the input synchronizers");
  end

  logic sclk_rise, sclk_fall, cs_rise, cs_fall, mosi_s;
  logic sclk_unused_lvl, cs_unused_lvl, mosi_unused_rise, mosi_unused_fall;

  spi_sync_edge #(.RST_VAL(1'b0), .EDGE_EN(1'b1)) u_sync_sclk (
    .clk(clock_1MHz), .rst_n(reset_n), .din(spi_sclk),
    .dout(sclk_unused_lvl), .rise(sclk_rise), .fall(sclk_fall)
  );

  // Resetting to 0 hides a cs_n that is already low at reset release until it rises.
  spi_sync_edge #(.RST_VAL(1'b0), .EDGE_EN(1'b1)) u_sync_cs (
    .clk(clock_1MHz), .rst_n(reset_n), .din(spi_cs_n),
    .dout(cs_unused_lvl), .rise(cs_rise), .fall(cs_fall)
  );

  spi_sync_edge #(.RST_VAL(1'b0), .EDGE_EN(1'b0)) u_sync_mosi (
    .clk(clock_1MHz), .rst_n(reset_n), .din(spi_mosi),
    .dout(mosi_s), .rise(mosi_unused_rise), .fall(mosi_unused_fall)
  );

  state_e      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [23:0] sr_q, sr_d;
  logic [7:0]  opcode_q, opcode_d;
  logic [23:0] set_time_q, set_time_d;
  logic        set_load_q, set_load_d;
  logic        mode_q, mode_d;
  logic        miso_q, miso_d;
  logic        err_abort_q, err_abort_d;
  logic        err_opcode_q, err_opcode_d;
  logic        err_range_q, err_range_d;

  logic [7:0] opcode_next;
  logic       op_known;
  logic       shifting;
  logic [7:0] status;

  assign opcode_next = {sr_q[6:0], mosi_s};
  assign op_known    = (opcode_next == OP_SET_TIME)   || (opcode_next == OP_SET_MODE) ||
                       (opcode_next == OP_CLEAR_TIME) || (opcode_next == OP_READ_STATUS);
  assign shifting    = ((state_q == ST_OPCODE) || (state_q == ST_PAYLOAD)) && sclk_rise && !cs_rise;

  always_comb begin
    status               = '0;
    status[STAT_MODE]    = mode_q;
    status[STAT_RANGE]   = err_range_q;
    status[STAT_OPCODE]  = err_opcode_q;
    status[STAT_ABORT]   = err_abort_q;
  end

  always_ff @(posedge clock_1MHz or negedge reset_n) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (cs_fall) state_d = ST_OPCODE;
      ST_OPCODE: begin
        if (cs_rise) begin
          state_d = ST_IDLE;
        end else if (sclk_rise && cnt_q == 5'd7) begin
          if (!op_known)                         state_d = ST_DRAIN;
          else if (opcode_next == OP_CLEAR_TIME) state_d = ST_EXECUTE;
          else                                   state_d = ST_PAYLOAD;
        end
      end
      ST_PAYLOAD: begin
        if (cs_rise)                                        state_d = ST_IDLE;
        else if (sclk_rise && cnt_q == last_bit(opcode_q)) state_d = ST_EXECUTE;
      end
      ST_EXECUTE: state_d = cs_rise ? ST_IDLE : ST_DRAIN;
      ST_DRAIN:   if (cs_rise) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    cnt_d        = cnt_q;
    sr_d         = sr_q;
    opcode_d     = opcode_q;
    set_time_d   = set_time_q;
    set_load_d   = 1'b0;
    mode_d       = mode_q;
    miso_d       = miso_q;
    err_abort_d  = err_abort_q;
    err_opcode_d = err_opcode_q;
    err_range_d  = err_range_q;

    if (state_q == ST_IDLE && cs_fall) cnt_d = '0;

    if (shifting) begin
      sr_d  = {sr_q[22:0], mosi_s};
      cnt_d = cnt_q + 5'd1;
      if (state_q == ST_OPCODE && cnt_q == 5'd7) begin
        opcode_d = opcode_next;
        if (!op_known) err_opcode_d = 1'b1;
      end
    end

    if ((state_q == ST_OPCODE || state_q == ST_PAYLOAD) && cs_rise) err_abort_d = 1'b1;

    if (state_q == ST_EXECUTE) begin
      unique case (opcode_q)
        OP_SET_TIME: begin
          if (time_ok(sr_q)) begin
            set_time_d = sr_q;
            set_load_d = 1'b1;
          end else begin
            err_range_d = 1'b1;
          end
        end
        OP_SET_MODE: mode_d = sr_q[0];
        OP_CLEAR_TIME: begin
          set_time_d = '0;
          set_load_d = 1'b1;
        end
        OP_READ_STATUS: begin
          err_abort_d  = 1'b0;
          err_opcode_d = 1'b0;
          err_range_d  = 1'b0;
        end
        default: ;
      endcase
    end

    // Falls 8..15 of a status read present status bits 7..0; every other fall drives 0.
    if (sclk_fall) begin
      if (state_q == ST_PAYLOAD && opcode_q == OP_READ_STATUS && cnt_q[4:3] == 2'b01)
        miso_d = status[~cnt_q[2:0]];
      else
        miso_d = 1'b0;
    end
  end

  always_ff @(posedge clock_1MHz or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q        <= '0;
      sr_q         <= '0;
      opcode_q     <= '0;
      set_time_q   <= '0;
      set_load_q   <= 1'b0;
      mode_q       <= 1'b0;
      miso_q       <= 1'b0;
      err_abort_q  <= 1'b0;
      err_opcode_q <= 1'b0;
      err_range_q  <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      sr_q         <= sr_d;
      opcode_q     <= opcode_d;
      set_time_q   <= set_time_d;
      set_load_q   <= set_load_d;
      mode_q       <= mode_d;
      miso_q       <= miso_d;
      err_abort_q  <= err_abort_d;
      err_opcode_q <= err_opcode_d;
      err_range_q  <= err_range_d;
    end
  end

  assign spi_miso = miso_q;
  assign set_time = set_time_q;
  assign set_load = set_load_q;
  assign mode_12h = mode_q;
  assign cmd_err  = err_abort_q | err_opcode_q | err_range_q;

endmodule
